// File: rtl/cpu_step_if.sv
// Handshake/status bundle between the step-button logic, the CPU and the
// single-step controller. Both sides see the same nets; direction comes
// from the modport.
interface cpu_step_if #(
    parameter int CNT_W = 16
);
    logic             step_pulse;
    logic             mode_run;
    logic             step_unit;
    logic             halt_req;
    logic             instr_done;
    logic             cpu_en;
    logic             busy;
    logic [1:0]       state;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    // Stimulus / CPU side: drives the requests, observes the enable and status
    modport master (
        output step_pulse, mode_run, step_unit, halt_req, instr_done,
        input  cpu_en, busy, state, timeout, cycle_cnt, instr_cnt
    );

    // Controller side
    modport slave (
        input  step_pulse, mode_run, step_unit, halt_req, instr_done,
        output cpu_en, busy, state, timeout, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run controller for the multi-cycle CPU. Turns debounced
// button pulses into a CPU clock enable (one cycle, one instruction, or a
// divided free-run) and keeps cycle/instruction counters for the display.
module cpu_step_ctrl #(
    parameter int RUN_DIV      = 4,
    parameter int MAX_STEP_CYC = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    cpu_step_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        STEP_CYC   = 2'b01,
        STEP_INSTR = 2'b10,
        RUN        = 2'b11
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(RUN_DIV - 1);
    localparam logic [7:0] WD_LAST  = 8'(MAX_STEP_CYC - 1);

    state_t           state_q, state_d;
    logic [7:0]       div_q, div_d;
    logic [7:0]       wdog_q, wdog_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;
    logic             cpu_en;

    // Enable is decoded purely from registers so the CPU sees a glitch-free level
    assign cpu_en = (state_q == STEP_CYC) || (state_q == STEP_INSTR) ||
                    ((state_q == RUN) && (div_q == DIV_LAST));

    assign bus.cpu_en    = cpu_en;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state     = state_q;
    assign bus.timeout   = timeout_q;
    assign bus.cycle_cnt = cyc_q;
    assign bus.instr_cnt = ins_q;

    // Next-state logic: halt_req wins over everything, mode_run over a step press
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        cyc_d     = cyc_q + CNT_W'(cpu_en);
        ins_d     = ins_q + CNT_W'(cpu_en && bus.instr_done);

        case (state_q)
            IDLE: begin
                if (bus.halt_req) begin
                    state_d = IDLE;
                end else if (bus.mode_run) begin
                    state_d = RUN;
                    div_d   = 8'd0;
                end else if (bus.step_pulse) begin
                    state_d   = bus.step_unit ? STEP_INSTR : STEP_CYC;
                    timeout_d = 1'b0;
                    wdog_d    = 8'd0;
                end
            end
            STEP_CYC: begin
                state_d = IDLE;
            end
            STEP_INSTR: begin
                wdog_d = wdog_q + 8'd1;
                if (bus.halt_req || bus.instr_done) begin
                    state_d = IDLE;
                end else if (wdog_q == WD_LAST) begin
                    // Instruction never finished: give up and flag it for the user
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            RUN: begin
                if (bus.halt_req || !bus.mode_run) begin
                    state_d = IDLE;
                    div_d   = 8'd0;
                end else begin
                    div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset aborts any step or run immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            wdog_q    <= 8'd0;
            timeout_q <= 1'b0;
            cyc_q     <= '0;
            ins_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl. Instance A uses RUN_DIV=4, MAX_STEP_CYC=16,
// CNT_W=16; instance B uses RUN_DIV=1, CNT_W=4 for free-run and wrap cases.
module tb_cpu_step_ctrl;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp = 0;
    int   n_err = 0;
    int   en_cnt;
    int   first_en;
    int   n;

    always #5 clk = ~clk;

    cpu_step_if #(.CNT_W(16)) a_if ();
    cpu_step_if #(.CNT_W(4))  b_if ();

    cpu_step_ctrl #(.RUN_DIV(4), .MAX_STEP_CYC(16), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_if.slave)
    );

    cpu_step_ctrl #(.RUN_DIV(1), .MAX_STEP_CYC(16), .CNT_W(4)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if.slave)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_if.step_pulse = 0; a_if.mode_run = 0; a_if.step_unit = 0; a_if.halt_req = 0; a_if.instr_done = 0;
        b_if.step_pulse = 0; b_if.mode_run = 0; b_if.step_unit = 0; b_if.halt_req = 0; b_if.instr_done = 0;
        tick(); tick();

        // Reset state
        chk("rst_state",   32'(a_if.state), 0);
        chk("rst_cpu_en",  32'(a_if.cpu_en), 0);
        chk("rst_busy",    32'(a_if.busy), 0);
        chk("rst_timeout", 32'(a_if.timeout), 0);
        chk("rst_cyc",     32'(a_if.cycle_cnt), 0);
        chk("rst_ins",     32'(a_if.instr_cnt), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // 1. Cycle steps: one-cycle enable, one cycle after each press
        for (int k = 0; k < 3; k++) begin
            a_if.step_unit  = 1'b0;
            a_if.step_pulse = 1'b1;
            chk("cs_pre_en", 32'(a_if.cpu_en), 0);
            tick();
            a_if.step_pulse = 1'b0;
            chk("cs_en",    32'(a_if.cpu_en), 1);
            chk("cs_state", 32'(a_if.state), 1);
            tick();
            chk("cs_en_off", 32'(a_if.cpu_en), 0);
            chk("cs_idle",   32'(a_if.state), 0);
            for (int j = 0; j < 8; j++) tick();
        end
        chk("cs_cyc", 32'(a_if.cycle_cnt), 3);

        // 2. Instruction step finished by instr_done on the 5th enable cycle
        a_if.step_unit  = 1'b1;
        a_if.step_pulse = 1'b1;
        tick();
        en_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            en_cnt += int'(a_if.cpu_en);
            chk("is_state", 32'(a_if.state), 2);
            a_if.step_pulse = (i == 2);
            a_if.step_unit  = (i == 2) ? 1'b0 : 1'b1;
            a_if.instr_done = (i == 5);
            tick();
        end
        a_if.step_pulse = 1'b0;
        a_if.instr_done = 1'b0;
        chk("is_en_cycles", 32'(en_cnt), 5);
        chk("is_idle",      32'(a_if.state), 0);
        chk("is_en_off",    32'(a_if.cpu_en), 0);
        chk("is_cyc",       32'(a_if.cycle_cnt), 8);
        chk("is_ins",       32'(a_if.instr_cnt), 1);
        chk("is_timeout",   32'(a_if.timeout), 0);
        tick();
        chk("is_pulse_ignored", 32'(a_if.state), 0);
        // instr_done with cpu_en low must not count
        a_if.instr_done = 1'b1;
        tick();
        a_if.instr_done = 1'b0;
        chk("idle_done_ignored", 32'(a_if.instr_cnt), 1);

        // 3. Watchdog: instr_done never arrives
        a_if.step_unit  = 1'b1;
        a_if.step_pulse = 1'b1;
        tick();
        a_if.step_pulse = 1'b0;
        n = 0;
        while (a_if.cpu_en && n < 40) begin
            n++;
            tick();
        end
        chk("wd_en_cycles", 32'(n), 16);
        chk("wd_idle",      32'(a_if.state), 0);
        chk("wd_timeout",   32'(a_if.timeout), 1);
        chk("wd_cyc",       32'(a_if.cycle_cnt), 24);
        tick();
        chk("wd_sticky",    32'(a_if.timeout), 1);
        a_if.step_unit  = 1'b0;
        a_if.step_pulse = 1'b1;
        tick();
        a_if.step_pulse = 1'b0;
        chk("wd_cleared",   32'(a_if.timeout), 0);
        chk("wd_step",      32'(a_if.state), 1);
        tick();
        chk("wd_cyc2",      32'(a_if.cycle_cnt), 25);

        // 4. Free run with RUN_DIV=4 for 40 cycles
        a_if.mode_run = 1'b1;
        tick();
        en_cnt = 0;
        first_en = -1;
        for (int i = 0; i < 40; i++) begin
            if (a_if.cpu_en && first_en < 0) first_en = i;
            en_cnt += int'(a_if.cpu_en);
            if (i == 39) a_if.mode_run = 1'b0;
            tick();
        end
        chk("run_pulses",   32'(en_cnt), 10);
        chk("run_first",    32'(first_en), 3);
        chk("run_stop",     32'(a_if.state), 0);
        chk("run_busy",     32'(a_if.busy), 0);
        en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            en_cnt += int'(a_if.cpu_en);
            tick();
        end
        chk("run_no_more",  32'(en_cnt), 0);
        chk("run_cyc",      32'(a_if.cycle_cnt), 35);

        // 5. Halt during RUN, halt in IDLE blocking run and step
        a_if.mode_run = 1'b1;
        tick(); tick(); tick();
        chk("halt_run_pre", 32'(a_if.state), 3);
        a_if.halt_req = 1'b1;
        tick();
        chk("halt_run",     32'(a_if.state), 0);
        tick();
        chk("halt_blk_run", 32'(a_if.state), 0);
        a_if.mode_run   = 1'b0;
        a_if.step_pulse = 1'b1;
        tick();
        a_if.step_pulse = 1'b0;
        chk("halt_blk_step", 32'(a_if.state), 0);
        a_if.halt_req = 1'b0;
        // Halt during STEP_INSTR: the enable of the halting cycle still counts
        a_if.step_unit  = 1'b1;
        a_if.step_pulse = 1'b1;
        tick();
        a_if.step_pulse = 1'b0;
        tick();
        a_if.halt_req = 1'b1;
        tick();
        a_if.halt_req = 1'b0;
        chk("halt_si",       32'(a_if.state), 0);
        chk("halt_si_en",    32'(a_if.cpu_en), 0);
        chk("halt_si_cyc",   32'(a_if.cycle_cnt), 37);
        chk("halt_si_to",    32'(a_if.timeout), 0);
        // Coincident mode_run and step_pulse: run wins, press dropped
        a_if.step_unit  = 1'b0;
        a_if.mode_run   = 1'b1;
        a_if.step_pulse = 1'b1;
        tick();
        a_if.step_pulse = 1'b0;
        a_if.mode_run   = 1'b0;
        chk("prio_run",      32'(a_if.state), 3);
        chk("prio_en",       32'(a_if.cpu_en), 0);
        tick();
        chk("prio_idle",     32'(a_if.state), 0);
        chk("prio_cyc",      32'(a_if.cycle_cnt), 37);

        // 6a. Counter wrap on the 4-bit instance: 17 cycle steps
        for (int k = 0; k < 17; k++) begin
            b_if.step_pulse = 1'b1;
            tick();
            b_if.step_pulse = 1'b0;
            tick();
        end
        chk("wrap_cyc",      32'(b_if.cycle_cnt), 1);
        // RUN_DIV=1: enable held high continuously
        b_if.mode_run = 1'b1;
        tick();
        en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            en_cnt += int'(b_if.cpu_en);
            if (i == 7) b_if.mode_run = 1'b0;
            tick();
        end
        chk("div1_en",       32'(en_cnt), 8);
        chk("div1_idle",     32'(b_if.state), 0);
        chk("div1_cyc",      32'(b_if.cycle_cnt), 9);

        // 6b. Reset in the middle of an instruction step
        a_if.step_unit  = 1'b1;
        a_if.step_pulse = 1'b1;
        tick();
        a_if.step_pulse = 1'b0;
        tick(); tick();
        chk("mid_pre",       32'(a_if.state), 2);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("mid_state",     32'(a_if.state), 0);
        chk("mid_en",        32'(a_if.cpu_en), 0);
        chk("mid_busy",      32'(a_if.busy), 0);
        chk("mid_timeout",   32'(a_if.timeout), 0);
        chk("mid_cyc",       32'(a_if.cycle_cnt), 0);
        chk("mid_ins",       32'(a_if.instr_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
